// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit ALU sequencer.
//   XLEN                 datapath width
//   OPC_*/RD_*/RS*/IMM_* instruction field bit positions
//   OP_*                 opcodes 0x00-0x13, plus the "returns zero" opcode
//   state_e              sequencer FSM states
package cpu19_pkg;

  localparam int XLEN  = 19;
  localparam int REG_W = 2;
  localparam int OPC_W = 5;
  localparam int IMM_W = 10;

  // Instruction field positions
  localparam int OPC_HI = 18;
  localparam int OPC_LO = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 12;
  localparam int RS1_HI = 11;
  localparam int RS1_LO = 10;
  localparam int RS2_HI = 9;
  localparam int RS2_LO = 8;
  localparam int IMM_HI = 9;
  localparam int IMM_LO = 0;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_ADD  = 5'h00;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'h01;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'h02;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'h03;
  localparam logic [OPC_W-1:0] OP_AND  = 5'h04;
  localparam logic [OPC_W-1:0] OP_OR   = 5'h05;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'h06;
  localparam logic [OPC_W-1:0] OP_SLL  = 5'h07;
  localparam logic [OPC_W-1:0] OP_MAC  = 5'h08;
  localparam logic [OPC_W-1:0] OP_SRL  = 5'h09;
  localparam logic [OPC_W-1:0] OP_SRA  = 5'h0A;
  localparam logic [OPC_W-1:0] OP_SLT  = 5'h0B;
  localparam logic [OPC_W-1:0] OP_SLTU = 5'h0C;
  localparam logic [OPC_W-1:0] OP_MIN  = 5'h0D;
  localparam logic [OPC_W-1:0] OP_MAX  = 5'h0E;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'h0F;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'h10;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'h11;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'h12;
  localparam logic [OPC_W-1:0] OP_XORI = 5'h13;
  // ALU answers 0 for this opcode; used to retire illegal instructions
  localparam logic [OPC_W-1:0] OP_ZERO = 5'h1F;

  localparam logic [XLEN-1:0] DIVZ_VAL = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MAC2,
    S_RESP
  } state_e;

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    return op <= OP_XORI;
  endfunction

  function automatic logic is_itype(input logic [OPC_W-1:0] op);
    return (op >= OP_ADDI) && (op <= OP_XORI);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer.
//   clk, rst       clock, synchronous active-high reset (clears all entries)
//   ra1/ra2        read addresses, rd1/rd2 combinational read data
//   we, wa, wd     synchronous write port
module alu_seq_regfile
  import cpu19_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  input  logic             we,
  input  logic [REG_W-1:0] wa,
  input  logic [XLEN-1:0]  wd
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end

  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external combinational 19-bit ALU.
// Decodes one instruction at a time, reads operands from a 4-entry register
// file, presents them to the ALU, writes the result back and reports it on a
// valid/ready result port. MAC is split into MUL then ADD against an internal
// accumulator so the ALU's own MAC opcode is never issued.
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_instr        instruction input handshake
//   alu_op1/op2/opcode/imm, alu_result  ALU interface (zero outside EXEC/MAC2)
//   out_valid/out_ready               retired-result handshake
//   out_rd/out_data/out_illegal       retired-result payload
//   trap                              sticky divide-by-zero flag
// Optional feature: define ALU_SEQ_DIVZERO_TRAP_EN to suppress the write on
// DIV by zero and raise trap; otherwise trap is tied 0.
module alu_sequencer
  import cpu19_pkg::*;
#(
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  output logic [OPC_W-1:0] alu_opcode,
  output logic [IMM_W-1:0] alu_imm,
  input  logic [XLEN-1:0]  alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_rd,
  output logic [XLEN-1:0]  out_data,
  output logic             out_illegal,
  output logic             trap
);

  state_e           state_q;
  logic [XLEN-1:0]  instr_q;
  logic [XLEN-1:0]  temp_q;
  logic [XLEN-1:0]  acc_q;
  logic             out_valid_q;
  logic [REG_W-1:0] out_rd_q;
  logic [XLEN-1:0]  out_data_q;
  logic             out_illegal_q;

  // Decoded fields of the latched instruction
  logic [OPC_W-1:0] op;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic [IMM_W-1:0] imm;
  logic             legal;

  assign op    = instr_q[OPC_HI:OPC_LO];
  assign rd    = instr_q[RD_HI:RD_LO];
  assign rs1   = instr_q[RS1_HI:RS1_LO];
  assign rs2   = instr_q[RS2_HI:RS2_LO];
  assign imm   = instr_q[IMM_HI:IMM_LO];
  assign legal = is_legal(op);

  logic [XLEN-1:0]  rdata1, rdata2;
  logic             rf_we;
  logic [XLEN-1:0]  rf_wd;
  logic             div_trap;

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  logic trap_q;
  assign div_trap = (op == OP_DIV) && (rdata2 == '0);
  assign trap     = trap_q;
`else
  assign div_trap = 1'b0;
  assign trap     = 1'b0;
`endif

  alu_seq_regfile #(.NREGS(NREGS)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rdata1),
    .rd2 (rdata2),
    .we  (rf_we),
    .wa  (rd),
    .wd  (rf_wd)
  );

  // ALU drive and writeback enable. The first MAC step only fills temp, so
  // only the second step writes the register file.
  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_opcode = '0;
    alu_imm    = '0;
    rf_we      = 1'b0;
    rf_wd      = alu_result;
    case (state_q)
      S_EXEC: begin
        alu_op1 = rdata1;
        alu_op2 = is_itype(op) ? '0 : rdata2;
        alu_imm = imm;
        if (!legal)            alu_opcode = OP_ZERO;
        else if (op == OP_MAC) alu_opcode = OP_MUL;
        else                   alu_opcode = op;
        rf_we = legal && (op != OP_MAC) && !div_trap;
      end
      S_MAC2: begin
        alu_op1    = temp_q;
        alu_op2    = acc_q;
        alu_opcode = OP_ADD;
        rf_we      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      temp_q        <= '0;
      acc_q         <= '0;
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_data_q    <= '0;
      out_illegal_q <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            instr_q <= in_instr;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          out_rd_q <= rd;
          if (!legal) begin
            out_data_q    <= '0;
            out_illegal_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else if (op == OP_MAC) begin
            temp_q  <= alu_result;
            state_q <= S_MAC2;
          end else begin
            // A trapped divide retires the all-ones quotient without writing
            out_data_q    <= div_trap ? DIVZ_VAL : alu_result;
            out_illegal_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= S_RESP;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
            if (div_trap) trap_q <= 1'b1;
`endif
          end
        end
        S_MAC2: begin
          acc_q         <= alu_result;
          out_data_q    <= alu_result;
          out_illegal_q <= 1'b0;
          out_valid_q   <= 1'b1;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_rd      = out_rd_q;
  assign out_data    = out_data_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import cpu19_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr = '0;
  logic [XLEN-1:0]  alu_op1, alu_op2;
  logic [OPC_W-1:0] alu_opcode;
  logic [IMM_W-1:0] alu_imm;
  logic [XLEN-1:0]  alu_result;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [REG_W-1:0] out_rd;
  logic [XLEN-1:0]  out_data;
  logic             out_illegal;
  logic             trap;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_imm(alu_imm), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_data(out_data), .out_illegal(out_illegal), .trap(trap)
  );

  // Environment ALU: only the opcodes this bench exercises
  always_comb begin
    case (alu_opcode)
      5'h00:   alu_result = alu_op1 + alu_op2;
      5'h02:   alu_result = alu_op1 * alu_op2;
      5'h03:   alu_result = (alu_op2 == '0) ? 19'h7FFFF : alu_op1 / alu_op2;
      5'h10:   alu_result = alu_op1 + {{9{alu_imm[9]}}, alu_imm};
      default: alu_result = '0;
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // MAC must never reach the ALU as opcode 0x08
  logic saw08 = 1'b0;
  always @(negedge clk) if (!rst && alu_opcode == 5'h08) saw08 = 1'b1;

  function automatic logic [18:0] mk_r(input logic [4:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 8'h00};
  endfunction

  function automatic logic [18:0] mk_i(input logic [4:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [9:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  // Snapshots from the first and second cycle after acceptance
  logic [4:0]  opc0, opc1;
  logic [18:0] op1_0;
  logic [9:0]  imm0;

  task automatic run(input logic [18:0] ins, output logic [18:0] d,
                     output logic [1:0] r, output logic il, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 10) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_instr = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; opc0 = alu_opcode; op1_0 = alu_op1; imm0 = alu_imm; opc1 = '0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
      if (lat == 2) opc1 = alu_opcode;
    end
    if (!out_valid) chk("valid_timeout", 0, 1);
    d = out_data; r = out_rd; il = out_illegal;
    @(posedge clk); #1;
  endtask

  logic [18:0] d;
  logic [1:0]  r;
  logic        il;
  int          lat;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_trap", trap, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_op1", alu_op1, 0);

    // ADDI R1,R0,-1
    run(mk_i(5'h10, 2'd1, 2'd0, 10'h3FF), d, r, il, lat);
    chk("addi_data", d, 19'h7FFFF);
    chk("addi_rd", r, 1);
    chk("addi_lat", lat, 2);
    chk("addi_op1", op1_0, 0);
    chk("addi_imm", imm0, 10'h3FF);
    chk("addi_ill", il, 0);
    chk("idle_after", in_ready, 1);

    // R1=6, R2=7, then two MACs into R3
    run(mk_i(5'h10, 2'd1, 2'd0, 10'd6), d, r, il, lat);
    chk("r1_6", d, 6);
    run(mk_i(5'h10, 2'd2, 2'd0, 10'd7), d, r, il, lat);
    chk("r2_7", d, 7);
    run(mk_r(5'h08, 2'd3, 2'd1, 2'd2), d, r, il, lat);
    chk("mac1_data", d, 42);
    chk("mac1_lat", lat, 3);
    chk("mac1_opc_mul", opc0, 5'h02);
    chk("mac1_opc_add", opc1, 5'h00);
    run(mk_r(5'h08, 2'd3, 2'd1, 2'd2), d, r, il, lat);
    chk("mac2_data", d, 84);
    chk("mac2_rd", r, 3);
    run(mk_i(5'h10, 2'd3, 2'd3, 10'd0), d, r, il, lat);
    chk("r3_read", d, 84);
    chk("no_op08", saw08, 0);

    // Illegal opcode 0x15
    run({5'h15, 2'd1, 2'd1, 10'h155}, d, r, il, lat);
    chk("ill_flag", il, 1);
    chk("ill_data", d, 0);
    chk("ill_rd", r, 1);
    run(mk_i(5'h10, 2'd1, 2'd1, 10'd0), d, r, il, lat);
    chk("ill_r1_kept", d, 6);
    chk("ill_clear", il, 0);
    run(mk_i(5'h10, 2'd2, 2'd2, 10'd0), d, r, il, lat);
    chk("ill_r2_kept", d, 7);

    // Backpressure: ADDI R2,R2,1 held in RESP for 5 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk_i(5'h10, 2'd2, 2'd2, 10'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_data", out_data, 8);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    run(mk_i(5'h10, 2'd2, 2'd2, 10'd0), d, r, il, lat);
    chk("bp_r2", d, 8);

    // DIV R1,R2,R0 with R0 = 0
    run(mk_r(5'h03, 2'd1, 2'd2, 2'd0), d, r, il, lat);
    chk("div0_data", d, 19'h7FFFF);
    run(mk_i(5'h10, 2'd1, 2'd1, 10'd0), d, r, il, lat);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    chk("div0_r1_kept", d, 6);
    chk("div0_trap_sticky", trap, 1);
`else
    chk("div0_r1_written", d, 19'h7FFFF);
    chk("div0_no_trap", trap, 0);
`endif

    // Reset during the second MAC step
    in_valid = 1'b1; in_instr = mk_r(5'h08, 2'd3, 2'd2, 2'd2);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_mac_add", alu_opcode, 5'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmac_in_ready", in_ready, 1);
    chk("rstmac_out_valid", out_valid, 0);
    chk("rstmac_trap", trap, 0);
    run(mk_i(5'h10, 2'd1, 2'd1, 10'd0), d, r, il, lat);
    chk("rstmac_r1", d, 0);
    run(mk_i(5'h10, 2'd1, 2'd0, 10'd2), d, r, il, lat);
    run(mk_i(5'h10, 2'd2, 2'd0, 10'd3), d, r, il, lat);
    run(mk_r(5'h08, 2'd3, 2'd1, 2'd2), d, r, il, lat);
    chk("rstmac_acc0", d, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-level sequencer that drives the combinational 19-bit ALU from a stream of 19-bit instruction words. It decodes each instruction, reads operands from a 4-entry register file, presents opcode/operands/immediate to the ALU, and writes the ALU result back. It also reports each retired result on a valid/ready output port. Multiply-accumulate runs as a two-step MUL then ADD against an internal accumulator, so the ALU's feedback MAC opcode is never driven.

## Interface
Parameters:
- `NREGS`, 4: register-file depth; fixed by the 2-bit register fields.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction word valid.
- `in_ready`  out  1  sequencer can accept an instruction.
- `in_instr`  in  19  instruction word.
- `alu_op1`, `alu_op2`  out  19  ALU operands.
- `alu_opcode`  out  5  ALU opcode.
- `alu_imm`  out  10  ALU immediate.
- `alu_result`  in  19  combinational ALU result.
- `out_valid`  out  1  retired result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_rd`  out  2  destination register.
- `out_data`  out  19  value written.
- `out_illegal`  out  1  the retired instruction was illegal; no write occurred.
- `trap`  out  1  sticky divide-by-zero flag (only with the macro).

## Operation
- Format:
  - `[18:14]` opcode.
  - `[13:12]` rd.
  - `[11:10]` rs1.
  - R-type: `[9:8]` rs2, `[7:0]` ignored.
  - I-type (opcodes 0x10–0x13): `[9:0]` imm.
- Legal opcodes: 0x00–0x13. Opcodes 0x14–0x1F are illegal.
- FSM states: IDLE, EXEC, MAC2, RESP.
  - IDLE: `in_ready`=1. On `in_valid`, latch the instruction and go to EXEC.
  - EXEC: drive `alu_op1`=R[rs1], `alu_op2`=R[rs2] (0 for I-type), `alu_opcode`, `alu_imm`=instr[9:0].
    - Non-MAC: capture `alu_result`, write R[rd], go to RESP.
    - MAC (0x08): drive opcode 0x02 (MUL), capture the product into a temp register, go to MAC2.
    - Illegal: drive opcode 0x1F (ALU returns 0), no write, set `out_illegal`, go to RESP.
  - MAC2: drive opcode 0x00 with op1=temp and op2=ACC. Write the result to both R[rd] and ACC, then go to RESP.
  - RESP: `out_valid`=1; hold `out_rd`, `out_data`, `out_illegal` stable until `out_ready`, then return to IDLE.
- ACC changes only on MAC. Arithmetic is 19-bit modulo; results are truncated to 19 bits.
- Register reads in EXEC see all prior writebacks (single-issue, so there are no hazards).
- When not in EXEC or MAC2, the ALU outputs are driven 0.

## Timing
- Instruction accepted at edge N:
  - non-MAC: `out_valid` asserts after edge N+1.
  - MAC: `out_valid` asserts after edge N+2.
- `in_ready` is low from acceptance until the cycle after the RESP handshake. Throughput is at most one instruction per 3 cycles (4 for MAC).
- `out_ready` held high: RESP lasts 1 cycle. Backpressure stalls the FSM in RESP indefinitely, with the register file unchanged.
- Reset takes priority in any state, including mid-MAC and during RESP. Reset values:
  - state=IDLE.
  - R0–R3=0, ACC=0, temp=0.
  - `out_valid`=0, `out_data`=0, `out_rd`=0, `out_illegal`=0.
  - `trap`=0.
  - ALU outputs 0.
  - `in_ready`=1 in the first cycle after reset deasserts.
  - An aborted MAC leaves ACC=0.

## Configuration
- `ALU_SEQ_DIVZERO_TRAP_EN`
  - Defined: DIV (0x03) with R[rs2]==0 suppresses the write, sets `trap` (sticky until `rst`), and retires with `out_data`=0x7FFFF.
  - Undefined: the `trap` port is tied 0, and DIV by zero writes 0x7FFFF to R[rd] as normal.

## Structure
- Shared package `cpu19_pkg`:
  - Opcode localparams (0x00–0x13, `OP_MAC`, `OP_MUL`, `OP_ADD`, `OP_DIV`).
  - Instruction field bit positions.
  - `XLEN`=19.
  - State enum.
- One sub-module `alu_seq_regfile`: 4×19 registers, 2 combinational read ports, 1 synchronous write port, sync reset.

## Test plan
- Reset, then ADDI R1,R0,imm=0x3FF → `alu_op1`=0, `alu_imm`=0x3FF, `out_rd`=1, `out_data`=0x7FFFF (sign-extended −1), latency 2.
- R1=6, R2=7 (via ADDI), then MAC R3,R1,R2 twice → `out_data`=42 then 84; ACC=84; ALU opcode observed 0x02 then 0x00, never 0x08.
- Opcode 0x15 → `out_illegal`=1, `out_data`=0, all registers unchanged.
- `out_ready` held low for 5 cycles in RESP → `in_ready`=0 and outputs stable throughout; release → IDLE next cycle.
- DIV R1,R2,R0 (R0=0):
  - with the macro: `trap`=1 and stays set, R1 unchanged.
  - without the macro: R1=0x7FFFF.
- Assert `rst` during MAC2 → next cycle `in_ready`=1, ACC=0, `out_valid`=0.
